ex_muldiv: RTL and testbench
============================

// Module: ex_muldiv
// PURPOSE
//  Execute-stage consumer of the ID/EX register fields for RV32M instructions
//  (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU). Decodes opcode/func_3/func_7,
//  runs an iterative shift-add multiply or restoring divide, and holds the
//  front of the pipeline (IF/ID, ID/EX) with a stall until the result is ready.
//  It then presents the result and destination to EX/MEM for one cycle.
// PARAMETERS
//  XLEN      32            operand/result width; iteration count = XLEN
//  M_OPCODE  7'b0110011    OP opcode carrying M-extension instructions
//  M_FUNC7   7'b0000001    func_7 value selecting the M extension
// PORTS
//  clk        in   1     clock, all state on posedge
//  rst        in   1     asynchronous reset, active-low
//  i_valid    in   1     ID/EX holds a valid instruction this cycle
//  i_flush    in   1     branch/jump flush; aborts any operation in flight
//  i_opcode   in   7     ID/EX opcode
//  i_func_3   in   3     ID/EX func_3 (000 MUL .. 111 REMU, RV32M order)
//  i_func_7   in   7     ID/EX func_7
//  i_rs_1     in   XLEN  ID/EX rs_1 operand value
//  i_rs_2     in   XLEN  ID/EX rs_2 operand value
//  i_rd_num   in   5     ID/EX destination register number
//  stall      out  1     hold IF/ID and ID/EX contents (combinational)
//  busy       out  1     FSM is in CALC
//  done       out  1     one-cycle pulse: result/rd_num are valid
//  result     out  XLEN  M-extension result
//  rd_num     out  5     destination register number for result
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, counter=0, result=0, rd_num=0, done=0.
//    stall and busy are forced to 0 while rst=0.
//  - start = i_valid & (i_opcode==M_OPCODE) & (i_func_7==M_FUNC7) & ~i_flush.
//  - FSM states:
//    - IDLE:
//      - start=1: latch operands, func_3 and rd_num; -> CALC, count=0.
//      - otherwise: stay in IDLE.
//    - CALC:
//      - Each cycle: one shift-add step (mul) or one restoring subtract step (div).
//      - count increments each cycle; when count==XLEN-1 -> DONE.
//    - DONE:
//      - done=1 and result/rd_num are registered valid; -> IDLE.
//  - stall = (IDLE & start) | CALC. stall=0 in DONE, so ID/EX advances at the
//    edge ending DONE and the same instruction is never re-launched.
//  - Latency: start seen in cycle 0. stall is high cycles 0..XLEN (XLEN+1 cycles).
//    done is high in cycle XLEN+1. Timing is fixed; there is no early-out.
//  - Signed handling: operand magnitudes are taken up front according to func_3.
//    - MULH: both operands signed.
//    - MULHSU: rs_1 signed, rs_2 unsigned.
//    - MULHU, DIVU, REMU: both operands unsigned.
//    - DIV, REM: both operands signed.
//    The unsigned core then runs, and the sign is applied at the end.
//  - Result sign and selection:
//    - MUL: low XLEN bits of the product (signedness irrelevant).
//    - MULH/MULHSU/MULHU: high XLEN bits of the 2*XLEN product; the product is
//      negated before selection when the operand signs differ.
//    - Quotient sign = sign(rs_1) ^ sign(rs_2).
//    - Remainder sign = sign(rs_1).
//  - Divide by zero (full latency still taken):
//    - DIV/DIVU return all ones.
//    - REM/REMU return rs_1 unchanged.
//  - Signed overflow, (-2^(XLEN-1)) / -1:
//    - DIV returns -2^(XLEN-1).
//    - REM returns 0.
//  - Non-M instructions, or i_valid=0: no state change, stall=0, done=0.
//  - i_flush=1 in CALC or DONE: -> IDLE next edge, done is suppressed, result unchanged.
//  - i_flush and start in the same cycle: flush wins, no launch.
//  - rd_num==0: the operation still runs and done pulses; the register file
//    discards the write to x0.
//  - rst asserted mid-operation: immediate abort to the reset values above.
//    The next start runs the full latency normally.
// TESTING
//  1. MUL rs_1=7, rs_2=0xFFFFFFFD -> result 0xFFFFFFEB;
//     stall high exactly 33 cycles, done pulse in cycle 33.
//  2. rs_1=rs_2=0xFFFFFFFF:
//     MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF.
//  3. rs_1=0xFFFFFFF9, rs_2=2: DIV -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU -> 0x7FFFFFFC.
//  4. Corner cases: DIVU 9/0 -> 0xFFFFFFFF; REM 5/0 -> 5;
//     DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
//  5. ADD (func_7=0) with i_valid=1 -> stall, busy and done stay 0 throughout.
//     Back-to-back MULs each get exactly one done pulse.
//  6. rst=0 in CALC cycle 10 -> stall/done/result 0 immediately.
//     i_flush in CALC cycle 5 -> no done. A following MUL 3*4 -> 12 at full latency.

Source files
------------

// File: rtl/ex_muldiv.sv
// RV32M execute unit: iterative shift-add multiply and restoring divide that
// stalls the front of the pipeline until its registered result is ready.
module ex_muldiv #(
  parameter int          XLEN     = 32,
  parameter logic [6:0]  M_OPCODE = 7'b0110011,
  parameter logic [6:0]  M_FUNC7  = 7'b0000001
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic            i_flush,
  input  logic [6:0]      i_opcode,
  input  logic [2:0]      i_func_3,
  input  logic [6:0]      i_func_7,
  input  logic [XLEN-1:0] i_rs_1,
  input  logic [XLEN-1:0] i_rs_2,
  input  logic [4:0]      i_rd_num,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_num,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [CW-1:0]       count;
  logic [2:0]          f3_q;
  logic                neg_a_q;
  logic                neg_b_q;
  logic                div_zero_q;
  logic [XLEN-1:0]     op_q;
  logic [XLEN-1:0]     rs1_q;
  logic [4:0]          rd_q;
  logic [2*XLEN-1:0]   acc;
  logic                done_r;

  logic                start;
  logic                a_signed;
  logic                b_signed;
  logic                neg_a;
  logic                neg_b;
  logic [XLEN-1:0]     a_mag;
  logic [XLEN-1:0]     b_mag;

  always_comb begin
    start    = i_valid & (i_opcode == M_OPCODE) & (i_func_7 == M_FUNC7) & ~i_flush;
    a_signed = (i_func_3 == 3'b001) | (i_func_3 == 3'b010) |
               (i_func_3 == 3'b100) | (i_func_3 == 3'b110);
    b_signed = (i_func_3 == 3'b001) | (i_func_3 == 3'b100) | (i_func_3 == 3'b110);
    neg_a    = a_signed & i_rs_1[XLEN-1];
    neg_b    = b_signed & i_rs_2[XLEN-1];
    a_mag    = neg_a ? -i_rs_1 : i_rs_1;
    b_mag    = neg_b ? -i_rs_2 : i_rs_2;
  end

  // acc holds {high product, multiplier} for mul and {remainder, dividend/quotient} for div.
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN:0]       div_shift;
  logic [XLEN+1:0]     div_diff;
  logic [2*XLEN-1:0]   div_next;
  logic [2*XLEN-1:0]   acc_next;
  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN-1:0]     quo;
  logic [XLEN-1:0]     rem;
  logic [XLEN-1:0]     res;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, op_q} : '0);
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, op_q};
    if (div_diff[XLEN+1])
      div_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    acc_next  = f3_q[2] ? div_next : mul_next;

    prod_s = (neg_a_q ^ neg_b_q) ? -acc_next : acc_next;
    quo    = acc_next[XLEN-1:0];
    rem    = acc_next[2*XLEN-1:XLEN];
    res    = '0;
    case (f3_q)
      3'b000:                 res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         res = div_zero_q ? '1 : ((neg_a_q ^ neg_b_q) ? -quo : quo);
      default:                res = div_zero_q ? rs1_q : (neg_a_q ? -rem : rem);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= '0;
      f3_q       <= '0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      div_zero_q <= 1'b0;
      op_q       <= '0;
      rs1_q      <= '0;
      rd_q       <= '0;
      acc        <= '0;
      done_r     <= 1'b0;
      result     <= '0;
      rd_num     <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            f3_q       <= i_func_3;
            neg_a_q    <= neg_a;
            neg_b_q    <= neg_b;
            div_zero_q <= (i_rs_2 == '0);
            rs1_q      <= i_rs_1;
            rd_q       <= i_rd_num;
            op_q       <= i_func_3[2] ? b_mag : a_mag;
            acc        <= {{XLEN{1'b0}}, (i_func_3[2] ? a_mag : b_mag)};
            count      <= '0;
            state      <= CALC;
          end
        end
        CALC: begin
          if (i_flush) begin
            count <= '0;
            state <= IDLE;
          end else begin
            acc   <= acc_next;
            count <= count + 1'b1;
            if (count == CW'(XLEN-1)) begin
              count  <= '0;
              done_r <= 1'b1;
              result <= res;
              rd_num <= rd_q;
              state  <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign done      = done_r & ~i_flush;
  assign busy      = rst & (state == CALC);
  assign stall     = rst & (((state == IDLE) & start) | (state == CALC));
  assign dbg_state = state;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed RV32M vectors, randomized operands against an
// arithmetic reference model, latency/stall counting, flush and reset abort.
module tb_ex_muldiv;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_valid, i_flush;
  logic [6:0]      i_opcode, i_func_7;
  logic [2:0]      i_func_3;
  logic [XLEN-1:0] i_rs_1, i_rs_2;
  logic [4:0]      i_rd_num;
  logic            stall, busy, done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_num;
  logic [1:0]      dbg_state;

  int              n_vec = 0;
  int              n_err = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] last_exp = '0;

  ex_muldiv dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_flush(i_flush),
    .i_opcode(i_opcode), .i_func_3(i_func_3), .i_func_7(i_func_7),
    .i_rs_1(i_rs_1), .i_rs_2(i_rs_2), .i_rd_num(i_rd_num),
    .stall(stall), .busy(busy), .done(done), .result(result),
    .rd_num(rd_num), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain 64-bit arithmetic and SV integer division.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    int         ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic idle_inputs();
    i_valid = 1'b0; i_flush = 1'b0; i_opcode = 7'h00; i_func_3 = 3'd0;
    i_func_7 = 7'h00; i_rs_1 = '0; i_rs_2 = '0; i_rd_num = '0;
  endtask

  task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    i_valid = 1'b1; i_flush = 1'b0; i_opcode = 7'b0110011; i_func_7 = 7'b0000001;
    i_func_3 = f3; i_rs_1 = a; i_rs_2 = b; i_rd_num = rd;
  endtask

  // Called at posedge+1; holds the instruction while stalled, returns at posedge+1 after done.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_val);
    int stall_cnt, done_cyc;
    logic [31:0] got, exp;
    logic [4:0]  got_rd;
    stall_cnt = 0; done_cyc = -1; got = '0; got_rd = '0;
    exp_q.push_back(exp_val);
    drive_op(f3, a, b, rd);
    for (int c = 0; c < 40 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      if (done) begin
        done_cyc = c; got = result; got_rd = rd_num;
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    exp = exp_q.pop_front();
    last_exp = exp;
    n_vec++;
    if (done_cyc !== 33) begin
      n_err++;
      $display("FAIL done_cycle f3=%0d a=%h b=%h: got %0d want 33", f3, a, b, done_cyc);
    end
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL result f3=%0d a=%h b=%h: got %h want %h", f3, a, b, got, exp);
    end
    n_vec++;
    if (got_rd !== rd) begin
      n_err++;
      $display("FAIL rd_num f3=%0d: got %0d want %0d", f3, got_rd, rd);
    end
    n_vec++;
    if (stall_cnt !== 33) begin
      n_err++;
      $display("FAIL stall_cycles f3=%0d: got %0d want 33", f3, stall_cnt);
    end
  endtask

  task automatic check_quiet(input string name);
    n_vec++;
    if ({stall, busy, done} !== 3'b000) begin
      n_err++;
      $display("FAIL %s: stall/busy/done got %b want 000", name, {stall, busy, done});
    end
  endtask

  task automatic check_reset_values(input string name);
    check_quiet(name);
    n_vec++;
    if (result !== '0 || rd_num !== '0) begin
      n_err++;
      $display("FAIL %s: result/rd_num got %h/%0d want 0/0", name, result, rd_num);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    drive_op(3'd0, 32'd3, 32'd4, 5'd1);
    @(negedge clk);
    check_reset_values("reset_hold");
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_spec_vectors();
    logic [2:0]  f3 [11] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] va [11] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                             32'hFFFFFFF9, 32'hFFFFFFF9, 32'd9, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] vb [11] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2,
                             32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ve [11] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD,
                             32'hFFFFFFFF, 32'h7FFFFFFC, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
    for (int i = 0; i < 11; i++) run_op(f3[i], va[i], vb[i], 5'(i + 3), ve[i]);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] a, b;
    logic [2:0]  f3;
    for (int i = 0; i < 30; i++) begin
      a  = pick_operand();
      b  = pick_operand();
      f3 = 3'($urandom_range(0, 7));
      run_op(f3, a, b, 5'($urandom_range(0, 31)), model(f3, a, b));
    end
  endtask

  task automatic test_non_m();
    drive_op(3'd0, 32'd5, 32'd6, 5'd2);
    i_func_7 = 7'h00;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk); check_quiet("add_ignored"); @(posedge clk); #1;
    end
    drive_op(3'd0, 32'd5, 32'd6, 5'd2);
    i_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); check_quiet("invalid_mul"); @(posedge clk); #1;
    end
    drive_op(3'd0, 32'd5, 32'd6, 5'd2);
    i_opcode = 7'b0010011;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); check_quiet("wrong_opcode"); @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom;
      run_op(3'd0, a, b, 5'(i), model(3'd0, a, b));
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); check_quiet("after_b2b"); @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    drive_op(3'd0, 32'd1234, 32'd5678, 5'd9);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    idle_inputs();
    #1;
    check_reset_values("reset_mid");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    run_op(3'd0, 32'd3, 32'd4, 5'd7, 32'd12);
  endtask

  task automatic test_flush();
    int seen;
    drive_op(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd4);
    repeat (5) @(posedge clk);
    #1;
    i_flush = 1'b1; i_valid = 1'b0;
    @(posedge clk); #1;
    i_flush = 1'b0;
    @(negedge clk);
    check_quiet("after_flush");
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); if (done) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++; $display("FAIL flush_no_done: got %0d done pulses want 0", seen);
    end
    n_vec++;
    if (result !== last_exp) begin
      n_err++; $display("FAIL flush_result_kept: got %h want %h", result, last_exp);
    end
    @(posedge clk); #1;
    drive_op(3'd0, 32'd3, 32'd4, 5'd6);
    i_flush = 1'b1;
    @(negedge clk);
    check_quiet("flush_with_start");
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check_quiet("flush_no_launch");
    @(posedge clk); #1;
    run_op(3'd0, 32'd3, 32'd4, 5'd6, 32'd12);
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_random();
    test_non_m();
    test_back_to_back();
    test_reset_mid();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
